// File: rtl/cross_sched_if.sv
// cross_sched_if: requester, response, shared cross-unit and statistics signals of cross_sched.
// slave is the scheduler side, master is the requester/cross-unit side.
interface cross_sched_if #(
  parameter int unsigned TOTAL_PREC = 27,
  parameter int unsigned NUM_REQ    = 2
);
  logic        [NUM_REQ-1:0]                        req_valid;
  logic        [NUM_REQ-1:0]                        req_ready;
  logic signed [NUM_REQ-1:0][2:0][TOTAL_PREC-1:0]   req_a;
  logic signed [NUM_REQ-1:0][2:0][TOTAL_PREC-1:0]   req_b;
  logic signed              [2:0][TOTAL_PREC-1:0]   cross_a;
  logic signed              [2:0][TOTAL_PREC-1:0]   cross_b;
  logic signed              [2:0][TOTAL_PREC-1:0]   cross_res;
  logic        [NUM_REQ-1:0]                        resp_valid;
  logic        [NUM_REQ-1:0]                        resp_ready;
  logic signed [NUM_REQ-1:0][2:0][TOTAL_PREC-1:0]   resp_res;
  logic        [15:0]                               stat_stall_cnt;

  modport slave (
    input  req_valid, req_a, req_b, cross_res, resp_ready,
    output req_ready, cross_a, cross_b, resp_valid, resp_res, stat_stall_cnt
  );

  modport master (
    output req_valid, req_a, req_b, cross_res, resp_ready,
    input  req_ready, cross_a, cross_b, resp_valid, resp_res, stat_stall_cnt
  );
endinterface

// File: rtl/cross_sched.sv
// cross_sched: round-robin scheduler sharing one fixed-latency cross-product unit among requesters,
// with credit-protected per-requester result FIFOs. Define CROSS_SCHED_STATS_EN for the stall counter.
module cross_sched #(
  parameter int unsigned TOTAL_PREC = 27,
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned LATENCY    = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  cross_sched_if.slave bus
);
  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + LATENCY + 2) + 1;

  typedef logic [2:0][TOTAL_PREC-1:0] vec_t;
  typedef logic [IDW-1:0]             id_t;

  id_t                r_ptr;
  vec_t               r_cross_a;
  vec_t               r_cross_b;
  logic               r_iss_vld;
  id_t                r_iss_id;
  logic               r_pipe_vld [LATENCY];
  id_t                r_pipe_id  [LATENCY];
  vec_t               r_mem      [NUM_REQ][FIFO_DEPTH];
  logic [AW-1:0]      r_wr       [NUM_REQ];
  logic [AW-1:0]      r_rd       [NUM_REQ];
  logic [AW:0]        r_cnt      [NUM_REQ];

  logic [CW-1:0]      w_infl     [NUM_REQ];
  logic [NUM_REQ-1:0] w_credit;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_ready;
  logic [NUM_REQ-1:0] w_push;
  logic [NUM_REQ-1:0] w_pop;
  logic [NUM_REQ-1:0] w_nempty;
  id_t                w_sel;
  id_t                w_idx;
  logic               w_found;
  logic               w_xfer;

  // Credit: buffered results plus ops still travelling through the issue register and pipe.
  always_comb begin
    w_infl   = '{default: '0};
    w_credit = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_infl[i] = CW'(r_iss_vld && (r_iss_id == IDW'(i)));
      for (int unsigned k = 0; k < LATENCY; k++) begin
        w_infl[i] = w_infl[i] + CW'(r_pipe_vld[k] && (r_pipe_id[k] == IDW'(i)));
      end
      w_credit[i] = (CW'(r_cnt[i]) + w_infl[i]) < CW'(FIFO_DEPTH);
    end
  end

  assign w_elig = bus.req_valid & w_credit;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    w_ready = '0;
    w_sel   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = IDW'((32'(r_ptr) + k) % NUM_REQ);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
    if (w_found && !rst) begin
      w_ready[w_sel] = 1'b1;
    end
  end

  assign w_xfer = w_found & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= IDW'(NUM_REQ - 1);
      r_cross_a <= '0;
      r_cross_b <= '0;
      r_iss_vld <= 1'b0;
      r_iss_id  <= '0;
      for (int unsigned k = 0; k < LATENCY; k++) begin
        r_pipe_vld[k] <= 1'b0;
        r_pipe_id[k]  <= '0;
      end
    end else begin
      if (w_xfer) begin
        r_ptr     <= w_sel;
        r_cross_a <= bus.req_a[w_sel];
        r_cross_b <= bus.req_b[w_sel];
      end
      r_iss_vld     <= w_xfer;
      r_iss_id      <= w_sel;
      r_pipe_vld[0] <= r_iss_vld;
      r_pipe_id[0]  <= r_iss_id;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        r_pipe_vld[k] <= r_pipe_vld[k-1];
        r_pipe_id[k]  <= r_pipe_id[k-1];
      end
    end
  end

  // The last pipe stage lines up with cross_res for the op it tags.
  always_comb begin
    w_push   = '0;
    w_nempty = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_push[i]   = r_pipe_vld[LATENCY-1] && (r_pipe_id[LATENCY-1] == IDW'(i));
      w_nempty[i] = (r_cnt[i] != '0);
    end
  end

  assign w_pop = w_nempty & bus.resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        r_wr[i]  <= '0;
        r_rd[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (w_push[i]) r_wr[i] <= r_wr[i] + AW'(1);
        if (w_pop[i])  r_rd[i] <= r_rd[i] + AW'(1);
        case ({w_push[i], w_pop[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + (AW+1)'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - (AW+1)'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_push[i]) r_mem[i][r_wr[i]] <= bus.cross_res;
    end
  end

  always_comb begin
    bus.resp_res = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      bus.resp_res[i] = w_nempty[i] ? r_mem[i][r_rd[i]] : '0;
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.resp_valid = w_nempty;
  assign bus.cross_a    = r_cross_a;
  assign bus.cross_b    = r_cross_b;

`ifdef CROSS_SCHED_STATS_EN
  logic [15:0] r_stall_cnt;

  // A stall is any cycle with a pending request and no transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if ((|bus.req_valid) && !w_xfer && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.stat_stall_cnt = r_stall_cnt;
`else
  assign bus.stat_stall_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_cross_sched.sv
// tb_cross_sched: directed tests for cross_sched with a fixed-latency Q22 cross-product model.
module tb_cross_sched;
  localparam int unsigned W    = 27;
  localparam int unsigned N    = 2;
  localparam int unsigned L    = 3;
  localparam int unsigned D    = 4;
  localparam int unsigned FRAC = 22;

`ifdef CROSS_SCHED_STATS_EN
  localparam logic [15:0] EXP_STALL = 16'd10;
`else
  localparam logic [15:0] EXP_STALL = 16'd0;
`endif

  typedef logic [2:0][W-1:0] vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t cpipe [L];

  always #5 clk = ~clk;

  cross_sched_if #(.TOTAL_PREC(W), .NUM_REQ(N)) bus ();

  cross_sched #(.TOTAL_PREC(W), .NUM_REQ(N), .LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic vec_t cross_fx(vec_t a, vec_t b);
    longint ax, ay, az, bx, by, bz;
    vec_t   r;
    ax = longint'($signed(a[0])); ay = longint'($signed(a[1])); az = longint'($signed(a[2]));
    bx = longint'($signed(b[0])); by = longint'($signed(b[1])); bz = longint'($signed(b[2]));
    r[0] = W'((ay * bz - az * by) >>> FRAC);
    r[1] = W'((az * bx - ax * bz) >>> FRAC);
    r[2] = W'((ax * by - ay * bx) >>> FRAC);
    return r;
  endfunction

  function automatic vec_t mk_a(int i, int n);
    vec_t v;
    v[0] = W'(((n % 8) + 1) * 4194304);
    v[1] = W'(-(i + 1) * 2097152);
    v[2] = W'((n % 8) * 1048576);
    return v;
  endfunction

  function automatic vec_t mk_b(int i, int n);
    vec_t v;
    v[0] = W'((i + 1) * 1048576);
    v[1] = W'(4194304);
    v[2] = W'(-((n % 8) + 1) * 524288);
    return v;
  endfunction

  // Shared cross unit: result appears L cycles after its operands.
  always @(posedge clk) begin
    cpipe[0] <= cross_fx(bus.cross_a, bus.cross_b);
    for (int k = 1; k < int'(L); k++) cpipe[k] <= cpipe[k-1];
  end
  assign bus.cross_res = cpipe[L-1];

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.req_valid  = '0;
    bus.resp_ready = '0;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.req_valid  = '1;
    bus.resp_ready = '1;
    bus.req_a[0] = mk_a(0, 1);
    bus.req_b[0] = mk_b(0, 1);
    tick; tick; #1;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", bus.req_ready); end
    checks++; if (bus.resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid got=%b exp=00", bus.resp_valid); end
    checks++; if (bus.cross_a !== '0) begin errors++; $display("FAIL reset_cross_a got=%h exp=0", bus.cross_a); end
    checks++; if (bus.cross_b !== '0) begin errors++; $display("FAIL reset_cross_b got=%h exp=0", bus.cross_b); end
    checks++; if (bus.resp_res !== '0) begin errors++; $display("FAIL reset_resp_res got=%h exp=0", bus.resp_res); end
    checks++; if (bus.stat_stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stat got=%0d exp=0", bus.stat_stall_cnt); end
  endtask

  task automatic test_single;
    vec_t a, b, e;
    a = '0; b = '0; e = '0;
    a[0] = W'(4194304);
    b[1] = W'(4194304);
    e[2] = W'(4194304);
    do_reset;
    bus.resp_ready = 2'b11;
    bus.req_valid  = 2'b01;
    bus.req_a[0] = a;
    bus.req_b[0] = b;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL single_grant got=%b exp=01", bus.req_ready); end
    tick;
    bus.req_valid = 2'b00;
    #1;
    checks++; if (bus.cross_a !== a) begin errors++; $display("FAIL single_cross_a got=%h exp=%h", bus.cross_a, a); end
    checks++; if (bus.cross_b !== b) begin errors++; $display("FAIL single_cross_b got=%h exp=%h", bus.cross_b, b); end
    for (int c = 1; c <= 4; c++) begin
      checks++; if (bus.resp_valid !== 2'b00) begin errors++; $display("FAIL single_early_valid cycle=%0d got=%b exp=00", c, bus.resp_valid); end
      tick; #1;
    end
    checks++; if (bus.resp_valid !== 2'b01) begin errors++; $display("FAIL single_latency got=%b exp=01", bus.resp_valid); end
    checks++; if (bus.resp_res[0] !== e) begin errors++; $display("FAIL single_result got=%h exp=%h", bus.resp_res[0], e); end
    checks++; if (bus.cross_a !== a) begin errors++; $display("FAIL single_hold got=%h exp=%h", bus.cross_a, a); end
    tick; #1;
    checks++; if (bus.resp_valid !== 2'b00) begin errors++; $display("FAIL single_pop got=%b exp=00", bus.resp_valid); end
  endtask

  task automatic test_alternate;
    vec_t sb [N][$];
    int   nop [N];
    int   got [N];
    int   g;
    logic [N-1:0] exp_rdy;
    nop = '{default: 0};
    got = '{default: 0};
    do_reset;
    bus.resp_ready = 2'b11;
    for (int cyc = 0; cyc < 20; cyc++) begin
      bus.req_valid = (cyc < 8) ? 2'b11 : 2'b00;
      for (int i = 0; i < int'(N); i++) begin
        bus.req_a[i] = mk_a(i, nop[i]);
        bus.req_b[i] = mk_b(i, nop[i]);
      end
      #1;
      if (cyc < 8) begin
        g = cyc % 2;
        exp_rdy = (g == 0) ? 2'b01 : 2'b10;
        checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL alt_grant cycle=%0d got=%b exp=%b", cyc, bus.req_ready, exp_rdy); end
        sb[g].push_back(cross_fx(mk_a(g, nop[g]), mk_b(g, nop[g])));
        nop[g]++;
      end
      for (int i = 0; i < int'(N); i++) begin
        if (bus.resp_valid[i]) begin
          checks++;
          if (sb[i].size() == 0 || bus.resp_res[i] !== sb[i][0]) begin
            errors++; $display("FAIL alt_resp req=%0d cycle=%0d got=%h", i, cyc, bus.resp_res[i]);
          end
          if (sb[i].size() != 0) void'(sb[i].pop_front());
          got[i]++;
        end
      end
      tick;
    end
    checks++; if (got[0] != 4) begin errors++; $display("FAIL alt_count0 got=%0d exp=4", got[0]); end
    checks++; if (got[1] != 4) begin errors++; $display("FAIL alt_count1 got=%0d exp=4", got[1]); end
  endtask

  task automatic test_backpressure;
    vec_t sb [N][$];
    int   iss0 [$];
    int   nop [N];
    int   held1, last, live0, g, n1_obs;
    logic c0, c1;
    logic [N-1:0] exp_rdy;
    nop = '{default: 0};
    held1 = 0; last = int'(N) - 1; n1_obs = 0;
    do_reset;
    bus.resp_ready = 2'b01;
    for (int cyc = 0; cyc < 30; cyc++) begin
      bus.req_valid = 2'b11;
      for (int i = 0; i < int'(N); i++) begin
        bus.req_a[i] = mk_a(i, nop[i]);
        bus.req_b[i] = mk_b(i, nop[i]);
      end
      #1;
      // Requester 0 holds a slot from issue until the cycle after its response pops.
      live0 = 0;
      foreach (iss0[k]) if (cyc < iss0[k] + 6) live0++;
      c0 = (live0 < int'(D));
      c1 = (held1 < int'(D));
      if (last == 0) g = c1 ? 1 : (c0 ? 0 : -1);
      else           g = c0 ? 0 : (c1 ? 1 : -1);
      exp_rdy = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
      checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL bp_grant cycle=%0d got=%b exp=%b", cyc, bus.req_ready, exp_rdy); end
      if (bus.req_ready[1]) n1_obs++;
      if (g >= 0) begin
        sb[g].push_back(cross_fx(mk_a(g, nop[g]), mk_b(g, nop[g])));
        nop[g]++;
        last = g;
        if (g == 0) iss0.push_back(cyc);
        else        held1++;
      end
      if (bus.resp_valid[0]) begin
        checks++;
        if (sb[0].size() == 0 || bus.resp_res[0] !== sb[0][0]) begin
          errors++; $display("FAIL bp_resp0 cycle=%0d got=%h", cyc, bus.resp_res[0]);
        end
        if (sb[0].size() != 0) void'(sb[0].pop_front());
      end
      tick;
    end
    checks++; if (n1_obs != 4) begin errors++; $display("FAIL bp_req1_transfers got=%0d exp=4", n1_obs); end
    bus.req_valid  = 2'b00;
    bus.resp_ready = 2'b11;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      for (int i = 0; i < int'(N); i++) begin
        if (bus.resp_valid[i]) begin
          checks++;
          if (sb[i].size() == 0 || bus.resp_res[i] !== sb[i][0]) begin
            errors++; $display("FAIL bp_drain req=%0d cycle=%0d got=%h", i, cyc, bus.resp_res[i]);
          end
          if (sb[i].size() != 0) void'(sb[i].pop_front());
        end
      end
      tick;
    end
    checks++; if (sb[1].size() != 0) begin errors++; $display("FAIL bp_missing1 got=%0d left exp=0", sb[1].size()); end
    checks++; if (sb[0].size() != 0) begin errors++; $display("FAIL bp_missing0 got=%0d left exp=0", sb[0].size()); end
  endtask

  task automatic test_stall;
    do_reset;
    bus.resp_ready = 2'b00;
    for (int cyc = 0; cyc < 14; cyc++) begin
      bus.req_valid = 2'b10;
      bus.req_a[1] = mk_a(1, cyc);
      bus.req_b[1] = mk_b(1, cyc);
      #1;
      if (cyc < 4) begin
        checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL stall_fill cycle=%0d got=%b exp=10", cyc, bus.req_ready); end
      end else begin
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL stall_full cycle=%0d got=%b exp=00", cyc, bus.req_ready); end
      end
      if (cyc == 4) begin
        checks++; if (bus.stat_stall_cnt !== 16'd0) begin errors++; $display("FAIL stall_start got=%0d exp=0", bus.stat_stall_cnt); end
      end
      tick;
    end
    bus.req_valid = 2'b00;
    #1;
    checks++; if (bus.stat_stall_cnt !== EXP_STALL) begin errors++; $display("FAIL stall_count got=%0d exp=%0d", bus.stat_stall_cnt, EXP_STALL); end
    checks++; if (bus.resp_valid !== 2'b10) begin errors++; $display("FAIL stall_buffered got=%b exp=10", bus.resp_valid); end
    tick; #1;
    checks++; if (bus.stat_stall_cnt !== EXP_STALL) begin errors++; $display("FAIL stall_idle got=%0d exp=%0d", bus.stat_stall_cnt, EXP_STALL); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    bus.resp_ready = 2'b11;
    for (int cyc = 0; cyc < 2; cyc++) begin
      bus.req_valid = 2'b01;
      bus.req_a[0] = mk_a(0, cyc);
      bus.req_b[0] = mk_b(0, cyc);
      #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL mid_issue cycle=%0d got=%b exp=01", cyc, bus.req_ready); end
      tick;
    end
    bus.req_valid = 2'b11;
    rst = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL mid_req_ready got=%b exp=00", bus.req_ready); end
    checks++; if (bus.cross_a !== '0 || bus.cross_b !== '0) begin errors++; $display("FAIL mid_cross got=%h/%h exp=0", bus.cross_a, bus.cross_b); end
    checks++; if (bus.resp_valid !== 2'b00 || bus.resp_res !== '0) begin errors++; $display("FAIL mid_resp got=%b/%h exp=0", bus.resp_valid, bus.resp_res); end
    checks++; if (bus.stat_stall_cnt !== 16'd0) begin errors++; $display("FAIL mid_stat got=%0d exp=0", bus.stat_stall_cnt); end
    tick;
    rst = 1'b0;
    bus.req_valid = 2'b00;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      checks++; if (bus.resp_valid !== 2'b00) begin errors++; $display("FAIL mid_stale cycle=%0d got=%b exp=00", cyc, bus.resp_valid); end
      tick;
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.resp_ready = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    test_reset;
    test_single;
    test_alternate;
    test_backpressure;
    test_stall;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
